ripple_carry_adder: RTL and testbench
=====================================

RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits; the block SHALL support any WIDTH >= 1.
REQ-002 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  operands valid this cycle.
REQ-006 a  input  WIDTH  operand A, unsigned; also read as two's complement for overflow.
REQ-007 b  input  WIDTH  operand B, same encoding as a.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 sum  output  WIDTH  registered sum bits, (a+b+cin) mod 2^WIDTH.
REQ-010 cout  output  1  registered carry out of bit WIDTH-1.
REQ-011 overflow  output  1  registered signed overflow, carry into MSB XOR carry out of MSB.
REQ-012 zero  output  1  registered flag, high when the registered sum is all zeros.
REQ-013 out_valid  output  1  registered; high when sum, cout, overflow and zero hold a new result.

Function
REQ-014 The datapath SHALL be a ripple chain of WIDTH one-bit full-adder stages: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = cin.
REQ-015 cout SHALL equal c[WIDTH]; overflow SHALL equal c[WIDTH]^c[WIDTH-1].
REQ-016 The chain SHALL be purely combinational from a, b and cin up to the output registers, with no intermediate pipeline registers.
REQ-017 Latency SHALL be exactly 1 cycle: operands sampled with in_valid=1 at edge N SHALL appear on the outputs after edge N, with out_valid=1.
REQ-018 On an edge with in_valid=0, out_valid SHALL go 0, and sum, cout, overflow and zero SHALL hold their previous values.
REQ-019 Back-to-back in_valid=1 SHALL produce one result per cycle with no bubbles; there is no backpressure.
REQ-020 zero SHALL be computed from the new sum in the same register update as the sum, not one cycle later.
REQ-021 Wrap-around: a result >= 2^WIDTH SHALL drop its upper bit into cout; sum keeps only the low WIDTH bits.
REQ-022 With a = b = all ones and cin = 1, the outputs SHALL be sum = all ones and cout = 1.
REQ-023 With WIDTH = 1, c[WIDTH-1] is cin, so overflow SHALL equal cin^cout.

Reset
REQ-024 On an edge with rst_n = 0, the block SHALL set sum = 0, cout = 0, overflow = 0, zero = 1 and out_valid = 0, regardless of in_valid.
REQ-025 Reset SHALL have priority over in_valid: operands presented on a reset edge SHALL be discarded and never produce out_valid.
REQ-026 On the first edge with rst_n = 1 and in_valid = 1, the block SHALL produce a normal result, with no extra idle cycle required.

Verification
REQ-027 A bench SHALL cover the following directed scenarios; all values are for WIDTH = 4, cin = 0 unless stated.
- Reset: rst_n = 0 for 2 cycles, in_valid = 1, a = 5, b = 6 -> sum = 0, cout = 0, overflow = 0, zero = 1, out_valid = 0.
- Sweep: a = t, b = (t+1) mod 16 for t = 0..15, one per cycle.
  - a = 3, b = 4 -> sum = 7, cout = 0, one cycle later.
  - a = 8, b = 9 -> sum = 1, cout = 1.
  - a = 15, b = 0 -> sum = 15, cout = 0.
- Signed overflow: a = 4, b = 5 -> sum = 9, cout = 0, overflow = 1.
- No signed overflow: a = 7, b = 8 -> sum = 15, overflow = 0.
- Full carry, zero flag: a = 15, b = 1 -> sum = 0, cout = 1, zero = 1.
- cin = 1, a = 15, b = 15 -> sum = 15, cout = 1.
- Hold and mid-stream reset:
  - After a valid result, drop in_valid for 3 cycles -> out_valid = 0 and outputs unchanged.
  - Assert rst_n = 0 mid-stream -> outputs take the reset values on that edge.
- Exhaustive: all 512 combinations of a, b and cin -> {cout, sum} = a + b + cin on every cycle.

Source files
------------

// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: WIDTH full-adder stages feeding one output register stage,
// with carry-out, signed overflow and zero flags and a valid strobe.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;
    logic             r_out_valid;

    // Carry ripples bit by bit; w_c_msb keeps the carry into the top stage for overflow.
    always_comb begin
        logic v_carry;
        v_carry = cin;
        w_sum   = '0;
        w_c_msb = cin;
        w_cout  = cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_c_msb  = v_carry;
            w_sum[i] = a[i] ^ b[i] ^ v_carry;
            v_carry  = (a[i] & b[i]) | (v_carry & (a[i] ^ b[i]));
        end
        w_cout = v_carry;
    end

    // Output register stage: zero is derived from the new sum, not the registered one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum      <= w_sum;
                r_cout     <= w_cout;
                r_overflow <= w_cout ^ w_c_msb;
                r_zero     <= (w_sum == '0);
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH = 4): directed, exhaustive and random
// steps compared against an arithmetic reference model.
module tb_ripple_carry_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic         out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;
    logic         m_ovf   = 1'b0;
    logic         m_zero  = 1'b1;
    logic         m_valid = 1'b0;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the reference model and compare every output.
    task automatic step(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vv, input logic vr);
        int total;
        int sa;
        int sb;
        int ss;
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = vv;
        rst_n    = vr;
        @(posedge clk);
        #1;
        if (!vr) begin
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
            m_zero  = 1'b1;
            m_valid = 1'b0;
        end else if (vv) begin
            total   = int'(va) + int'(vb) + int'(vc);
            sa      = (int'(va) >= (1 << (W - 1))) ? int'(va) - (1 << W) : int'(va);
            sb      = (int'(vb) >= (1 << (W - 1))) ? int'(vb) - (1 << W) : int'(vb);
            ss      = sa + sb + int'(vc);
            m_sum   = W'(total % (1 << W));
            m_cout  = (total >= (1 << W));
            m_ovf   = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
            m_zero  = (m_sum == '0);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        chk({tag, ".sum"},       32'(sum),       32'(m_sum));
        chk({tag, ".cout"},      32'(cout),      32'(m_cout));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".zero"},      32'(zero),      32'(m_zero));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    endtask

    initial begin
        // Reset held two cycles with live operands that must be discarded
        step("reset0", 4'd5, 4'd6, 1'b0, 1'b1, 1'b0);
        step("reset1", 4'd5, 4'd6, 1'b0, 1'b1, 1'b0);
        chk("reset.sum_const",  32'(sum),       32'd0);
        chk("reset.zero_const", 32'(zero),      32'd1);
        chk("reset.vld_const",  32'(out_valid), 32'd0);

        // First cycle out of reset produces a result immediately
        for (int t = 0; t < 16; t++)
            step("sweep", W'(t), W'((t + 1) % 16), 1'b0, 1'b1, 1'b1);
        step("add3p4", 4'd3, 4'd4, 1'b0, 1'b1, 1'b1);
        chk("add3p4.sum_const", 32'(sum), 32'd7);
        step("add8p9", 4'd8, 4'd9, 1'b0, 1'b1, 1'b1);
        chk("add8p9.sum_const",  32'(sum),  32'd1);
        chk("add8p9.cout_const", 32'(cout), 32'd1);

        step("ovf4p5", 4'd4, 4'd5, 1'b0, 1'b1, 1'b1);
        chk("ovf4p5.sum_const", 32'(sum),      32'd9);
        chk("ovf4p5.ovf_const", 32'(overflow), 32'd1);
        step("noovf7p8", 4'd7, 4'd8, 1'b0, 1'b1, 1'b1);
        chk("noovf7p8.ovf_const", 32'(overflow), 32'd0);
        step("wrap15p1", 4'd15, 4'd1, 1'b0, 1'b1, 1'b1);
        chk("wrap15p1.zero_const", 32'(zero), 32'd1);
        chk("wrap15p1.cout_const", 32'(cout), 32'd1);
        step("cin15p15", 4'd15, 4'd15, 1'b1, 1'b1, 1'b1);
        chk("cin15p15.sum_const",  32'(sum),  32'd15);
        chk("cin15p15.cout_const", 32'(cout), 32'd1);

        // Hold: in_valid low keeps the previous result, junk operands ignored
        step("pre_hold", 4'd7, 4'd8, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            step("hold", 4'd1, 4'd2, 1'b1, 1'b0, 1'b1);
        chk("hold.sum_const", 32'(sum), 32'd15);

        step("stream", 4'd9, 4'd3, 1'b0, 1'b1, 1'b1);
        step("midreset", 4'd9, 4'd3, 1'b0, 1'b1, 1'b0);
        step("postreset", 4'd2, 4'd2, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 512; i++)
            step("exh", W'(i), W'(i >> 4), 1'(i >> 8), 1'b1, 1'b1);

        for (int r = 0; r < 300; r++)
            step("rand", W'($urandom), W'($urandom), 1'($urandom),
                 ($urandom_range(3) != 0), ($urandom_range(15) != 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
